fp_multifunc_issuer: RTL and testbench

- Requester-side front end for a combinational low-power FP multifunction unit; the unit itself is instantiated outside this block.
- Accepts operation requests over a valid/ready handshake and drives the unit's a/func/rnd inputs from registers.
- Captures the unit's z/status into a back-pressurable response stage and maintains a sticky exception-flag register for software.

---
 rtl/fp_multifunc_issuer.sv | 141 ++++++++++++++
 tb/tb_fp_multifunc_issuer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multifunc_issuer.sv
// Requester-side front end for an external combinational FP multifunction unit.
// S1 holds the accepted request and drives fu_*; S2 registers the unit's
// result for a back-pressurable response port. A sticky flag register
// accumulates the status bytes of delivered responses.
// Optional feature macro: FP_MF_ISSUER_PERF_EN adds perf_ops/perf_stall counters.
module fp_multifunc_issuer #(
   parameter int SIG_WIDTH   = 23,
   parameter int EXP_WIDTH   = 8,
   parameter int FUNC_SELECT = 127,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [SIG_WIDTH+EXP_WIDTH:0]   req_a,
   input  logic [15:0]                    req_func,
   input  logic [2:0]                     req_rnd,
   input  logic [TAG_WIDTH-1:0]           req_tag,
   output logic [SIG_WIDTH+EXP_WIDTH:0]   fu_a,
   output logic [15:0]                    fu_func,
   output logic [2:0]                     fu_rnd,
   input  logic [SIG_WIDTH+EXP_WIDTH:0]   fu_z,
   input  logic [7:0]                     fu_status,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [SIG_WIDTH+EXP_WIDTH:0]   rsp_z,
   output logic [7:0]                     rsp_status,
   output logic [TAG_WIDTH-1:0]           rsp_tag,
   output logic [7:0]                     flags,
   input  logic                           flags_clr,
`ifdef FP_MF_ISSUER_PERF_EN
   output logic [15:0]                    perf_ops,
   output logic [15:0]                    perf_stall,
`endif
   output logic                           busy
);

   localparam int W = SIG_WIDTH + EXP_WIDTH + 1;
   localparam logic [15:0] FUNC_MASK = 16'(FUNC_SELECT);
   // Canonical quiet NaN: sign 0, exponent all ones, significand MSB set.
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
   localparam logic [7:0] STATUS_INVALID = 8'h04;

   logic                 s1_v;
   logic                 s1_illegal;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic                 s2_free;
   logic                 s1_adv;
   logic                 req_fire;
   logic                 rsp_fire;
   logic                 req_legal;

   // Handshake/stall decode; req_ready follows rsp_ready combinationally.
   always_comb begin
      s2_free   = !rsp_valid || rsp_ready;
      s1_adv    = s1_v && s2_free;
      req_ready = !s1_v || s2_free;
      req_fire  = req_valid && req_ready;
      rsp_fire  = rsp_valid && rsp_ready;
      busy      = s1_v || rsp_valid;
      req_legal = (req_func != '0) &&
                  ((req_func & (req_func - 16'd1)) == '0) &&
                  ((req_func & FUNC_MASK) != '0);
   end

   // S1: capture request; fu_* only move on a legal accept so the unit stays quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v       <= 1'b0;
         s1_illegal <= 1'b0;
         s1_tag     <= '0;
         fu_a       <= '0;
         fu_func    <= '0;
         fu_rnd     <= '0;
      end else if (req_fire) begin
         s1_v       <= 1'b1;
         s1_illegal <= !req_legal;
         s1_tag     <= req_tag;
         if (req_legal) begin
            fu_a    <= req_a;
            fu_func <= req_func;
            fu_rnd  <= req_rnd;
         end
      end else if (s1_adv) begin
         s1_v <= 1'b0;
      end
   end

   // S2: response register, held stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_z      <= '0;
         rsp_status <= '0;
         rsp_tag    <= '0;
      end else if (s1_adv) begin
         rsp_valid <= 1'b1;
         rsp_tag   <= s1_tag;
         if (s1_illegal) begin
            rsp_z      <= QNAN;
            rsp_status <= STATUS_INVALID;
         end else begin
            rsp_z      <= fu_z;
            rsp_status <= fu_status;
         end
      end else if (rsp_fire) begin
         rsp_valid <= 1'b0;
      end
   end

   // Sticky flags: a clear coinciding with a handshake keeps only that status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
      end else if (flags_clr) begin
         flags <= rsp_fire ? rsp_status : '0;
      end else if (rsp_fire) begin
         flags <= flags | rsp_status;
      end
   end

`ifdef FP_MF_ISSUER_PERF_EN
   // Saturating counters for delivered ops and stalled response cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_ops   <= '0;
         perf_stall <= '0;
      end else if (flags_clr) begin
         perf_ops   <= '0;
         perf_stall <= '0;
      end else begin
         if (rsp_fire && (perf_ops != '1))
            perf_ops <= perf_ops + 16'd1;
         if (rsp_valid && !rsp_ready && (perf_stall != '1))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_multifunc_issuer.sv
// Testbench for fp_multifunc_issuer: directed vector table, hand-written
// multi-cycle sequences and a randomized phase, all checked by a per-cycle
// transaction-level reference model (queue of expected responses).
module tb_fp_multifunc_issuer;

   localparam int SIGW = 23;
   localparam int EXPW = 8;
   localparam int FSEL = 127;
   localparam int TAGW = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [15:0] req_func;
   logic [2:0]  req_rnd;
   logic [3:0]  req_tag;
   logic [31:0] fu_a;
   logic [15:0] fu_func;
   logic [2:0]  fu_rnd;
   logic [31:0] fu_z;
   logic [7:0]  fu_status;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_z;
   logic [7:0]  rsp_status;
   logic [3:0]  rsp_tag;
   logic [7:0]  flags;
   logic        flags_clr;
   logic        busy;
`ifdef FP_MF_ISSUER_PERF_EN
   logic [15:0] perf_ops;
   logic [15:0] perf_stall;
`endif

   fp_multifunc_issuer #(
      .SIG_WIDTH  (SIGW),
      .EXP_WIDTH  (EXPW),
      .FUNC_SELECT(FSEL),
      .TAG_WIDTH  (TAGW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_func  (req_func),
      .req_rnd   (req_rnd),
      .req_tag   (req_tag),
      .fu_a      (fu_a),
      .fu_func   (fu_func),
      .fu_rnd    (fu_rnd),
      .fu_z      (fu_z),
      .fu_status (fu_status),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .rsp_status(rsp_status),
      .rsp_tag   (rsp_tag),
      .flags     (flags),
      .flags_clr (flags_clr),
`ifdef FP_MF_ISSUER_PERF_EN
      .perf_ops  (perf_ops),
      .perf_stall(perf_stall),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Stand-in for the external combinational unit.
   function automatic logic [31:0] unit_z(logic [31:0] a, logic [15:0] f, logic [2:0] r);
      return a + {f, 16'h0000} + {29'd0, r};
   endfunction
   function automatic logic [7:0] unit_st(logic [31:0] a, logic [15:0] f, logic [2:0] r);
      return a[7:0] ^ f[15:8] ^ {5'd0, r};
   endfunction

   always_comb begin
      fu_z      = unit_z(fu_a, fu_func, fu_rnd);
      fu_status = unit_st(fu_a, fu_func, fu_rnd);
   end

   typedef struct {
      logic [31:0] z;
      logic [7:0]  st;
      logic [3:0]  tag;
   } rsp_t;

   function automatic bit is_legal(logic [15:0] f);
      return ($countones(f) == 1) && ((f & 16'(FSEL)) != 16'h0);
   endfunction

   function automatic rsp_t expect_rsp(logic [31:0] a, logic [15:0] f, logic [2:0] r, logic [3:0] t);
      rsp_t e;
      e.tag = t;
      if (is_legal(f)) begin
         e.z  = unit_z(a, f, r);
         e.st = unit_st(a, f, r);
      end else begin
         e.z  = 32'h7FC00000;
         e.st = 8'h04;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // ---------------- reference model / monitor ----------------
   rsp_t        q[$];
   bit          mrv;
   logic [7:0]  mflags;

   always @(negedge clk) begin
      bit   s1occ, s2free, hs, adv;
      rsp_t e;
      if (!rst_n) begin
         q.delete();
         mrv    = 1'b0;
         mflags = 8'h00;
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_req_ready", req_ready, 1);
         chk("rst_rsp_z", rsp_z, 0);
         chk("rst_rsp_status", rsp_status, 0);
         chk("rst_rsp_tag", rsp_tag, 0);
         chk("rst_fu_a", fu_a, 0);
         chk("rst_fu_func", fu_func, 0);
         chk("rst_fu_rnd", fu_rnd, 0);
         chk("rst_flags", flags, 0);
         chk("rst_busy", busy, 0);
      end else begin
         s1occ  = q.size() > (mrv ? 1 : 0);
         s2free = !mrv || rsp_ready;
         chk("mon_rsp_valid", rsp_valid, mrv);
         chk("mon_req_ready", req_ready, !s1occ || s2free);
         chk("mon_busy", busy, q.size() != 0);
         chk("mon_flags", flags, mflags);
         if (mrv) begin
            chk("mon_rsp_z", rsp_z, q[0].z);
            chk("mon_rsp_status", rsp_status, q[0].st);
            chk("mon_rsp_tag", rsp_tag, q[0].tag);
         end
         hs  = mrv && rsp_ready;
         adv = s1occ && s2free;
         if (flags_clr)
            mflags = hs ? q[0].st : 8'h00;
         else if (hs)
            mflags = mflags | q[0].st;
         if (hs)
            void'(q.pop_front());
         mrv = adv || (mrv && !rsp_ready);
         if (req_valid && (!s1occ || s2free)) begin
            e = expect_rsp(req_a, req_func, req_rnd, req_tag);
            q.push_back(e);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [31:0] a, input logic [15:0] f, input logic [2:0] r,
                           input logic [3:0] t, output int waited);
      bit got;
      got    = 1'b0;
      waited = 0;
      req_a = a; req_func = f; req_rnd = r; req_tag = t; req_valid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
         else waited++;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!got) fail_now("send_req_timeout");
   endtask

   typedef struct {
      logic [31:0] a;
      logic [15:0] func;
      logic [2:0]  rnd;
      logic [3:0]  tag;
      bit          legal;
      rsp_t        exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      logic [31:0] prev_a;
      logic [15:0] prev_f;
      logic [2:0]  prev_r;
      logic [7:0]  acc;
      logic [31:0] snap_z;
      int          cnt;

      vecs[0] = '{32'h40800000, 16'h0002, 3'd0, 4'd3,  1'b1, '{32'h0, 8'h0, 4'h0}};
      vecs[1] = '{32'h3F800005, 16'h0001, 3'd2, 4'd1,  1'b1, '{32'h0, 8'h0, 4'h0}};
      vecs[2] = '{32'h12345678, 16'h0003, 3'd1, 4'd9,  1'b0, '{32'h0, 8'h0, 4'h0}};
      vecs[3] = '{32'hDEADBEEF, 16'h0100, 3'd4, 4'd10, 1'b0, '{32'h0, 8'h0, 4'h0}};
      vecs[4] = '{32'hC0000020, 16'h0040, 3'd1, 4'd15, 1'b1, '{32'h0, 8'h0, 4'h0}};
      vecs[5] = '{32'h0BADF00D, 16'h0000, 3'd7, 4'd2,  1'b0, '{32'h0, 8'h0, 4'h0}};
      foreach (vecs[i])
         vecs[i].exp = expect_rsp(vecs[i].a, vecs[i].func, vecs[i].rnd, vecs[i].tag);

      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_func = '0; req_rnd = '0;
      req_tag = '0; rsp_ready = 1'b1; flags_clr = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // ---- vector table: single ops incl. illegal functions ----
      acc = 8'h00;
      foreach (vecs[i]) begin
         prev_a = fu_a; prev_f = fu_func; prev_r = fu_rnd;
         send_req(vecs[i].a, vecs[i].func, vecs[i].rnd, vecs[i].tag, w);
         chk("vec_accept_wait", w, 0);
         @(negedge clk);
         chk("vec_fu_a", fu_a, vecs[i].legal ? vecs[i].a : prev_a);
         chk("vec_fu_func", fu_func, vecs[i].legal ? vecs[i].func : prev_f);
         chk("vec_fu_rnd", fu_rnd, vecs[i].legal ? vecs[i].rnd : prev_r);
         chk("vec_rsp_early", rsp_valid, 0);
         @(negedge clk);
         chk("vec_rsp_valid", rsp_valid, 1);
         chk("vec_rsp_z", rsp_z, vecs[i].exp.z);
         chk("vec_rsp_status", rsp_status, vecs[i].exp.st);
         chk("vec_rsp_tag", rsp_tag, vecs[i].tag);
         acc = acc | vecs[i].exp.st;
         @(negedge clk);
         chk("vec_flags", flags, acc);
         if (!vecs[i].legal) chk("vec_flag_invalid", flags[2], 1);
         tick();
      end

      // ---- back-to-back: 4 ops on consecutive cycles ----
      for (int t = 0; t < 4; t++) begin
         send_req(32'h3F000000 + 32'(t), 16'h0004, 3'(t), 4'(t), w);
         chk("b2b_no_wait", w, 0);
      end
      repeat (4) tick();
      chk("b2b_idle", busy, 0);

      // ---- backpressure ----
      rsp_ready = 1'b0;
      req_a = 32'h11110000; req_func = 16'h0008; req_rnd = 3'd0; req_tag = 4'd5; req_valid = 1'b1;
      tick();
      req_a = 32'h22220000; req_func = 16'h0010; req_tag = 4'd6;
      tick();
      req_a = 32'h33330000; req_func = 16'h0020; req_tag = 4'd7;
      @(negedge clk);
      chk("bp_req_ready_low", req_ready, 0);
      chk("bp_head_tag", rsp_tag, 5);
      snap_z = rsp_z;
      tick();
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_z", rsp_z, snap_z);
      chk("bp_hold_tag", rsp_tag, 5);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_req_ready_release", req_ready, 1);
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      chk("bp_drained", busy, 0);

      // ---- flags clear coinciding with a handshake ----
      flags_clr = 1'b1;
      tick();
      flags_clr = 1'b0;
      send_req(32'h3F800005, 16'h0001, 3'd0, 4'd1, w);
      repeat (3) tick();
      chk("fc_flags_05", flags, 8'h05);
      rsp_ready = 1'b0;
      send_req(32'h00000020, 16'h0001, 3'd0, 4'd2, w);
      tick();
      flags_clr = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("fc_status_20", rsp_status, 8'h20);
      chk("fc_flags_before", flags, 8'h05);
      tick();
      flags_clr = 1'b0;
      @(negedge clk);
      chk("fc_flags_after", flags, 8'h20);
      tick();

      // ---- reset mid-flight with S1 and S2 full ----
      rsp_ready = 1'b0;
      send_req(32'h40400000, 16'h0002, 3'd0, 4'd11, w);
      send_req(32'h40A00000, 16'h0004, 3'd0, 4'd12, w);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_flags", flags, 0);
      chk("mid_rst_fu_func", fu_func, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      rsp_ready = 1'b1;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("mid_rst_no_rsp", cnt, 0);
      tick();

      // ---- randomized traffic ----
      for (int c = 0; c < 400; c++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_a     = $urandom;
         req_rnd   = 3'($urandom_range(0, 7));
         req_tag   = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0, 1:    req_func = 16'h0001 << $urandom_range(0, 6);
            2:       req_func = 16'h0001 << $urandom_range(0, 15);
            default: req_func = 16'($urandom);
         endcase
         rsp_ready = ($urandom_range(0, 3) != 0);
         flags_clr = ($urandom_range(0, 15) == 0);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      flags_clr = 1'b0;
      repeat (5) tick();
      chk("rand_drained", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
